// File: rtl/wb_sram_arb.sv
// Round-robin Wishbone arbiter: shares one WB slave (the SRAM controller) between NUM_MASTERS
// masters. Ownership is held for as long as the owner keeps cyc asserted. A watchdog returns err
// if the slave stalls, so a hung slave cannot lock the bus.
module wb_sram_arb #(
    parameter int unsigned NUM_MASTERS = 3,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_MASTERS-1:0]    m_cyc_i,
    input  logic [NUM_MASTERS-1:0]    m_stb_i,
    input  logic [NUM_MASTERS-1:0]    m_we_i,
    input  logic [32*NUM_MASTERS-1:0] m_adr_i,
    input  logic [4*NUM_MASTERS-1:0]  m_sel_i,
    input  logic [32*NUM_MASTERS-1:0] m_dat_i,
    output logic [31:0]               m_dat_o,
    output logic [NUM_MASTERS-1:0]    m_ack_o,
    output logic [NUM_MASTERS-1:0]    m_err_o,
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic                      s_we_o,
    output logic [31:0]               s_adr_o,
    output logic [3:0]                s_sel_o,
    output logic [31:0]               s_dat_o,
    input  logic [31:0]               s_dat_i,
    input  logic                      s_ack_i,
    output logic [NUM_MASTERS-1:0]    grant_o
);

    localparam int unsigned IdxW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    // One extra bit so pointer + offset cannot overflow before the wrap subtraction.
    localparam int unsigned ExtW = IdxW + 1;
    localparam logic [7:0]      TimeoutCnt = 8'(TIMEOUT);
    localparam logic [IdxW-1:0] LastIdx    = IdxW'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StGap} state_e;

    state_e                 state_q;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [IdxW-1:0]        owner_q;
    logic [IdxW-1:0]        last_q;
    logic [7:0]             wdog_q;

    logic                   owner_cyc;
    logic                   owner_stb;
    logic [IdxW-1:0]        pick_idx;
    logic [NUM_MASTERS-1:0] pick_oh;
    logic                   ack_ok;
    logic                   timeout;

    // Round-robin pick: first requester after the last owner, wrapping at NUM_MASTERS-1.
    always_comb begin
        logic            found;
        logic [ExtW-1:0] idx;
        found    = 1'b0;
        idx      = '0;
        pick_idx = '0;
        pick_oh  = '0;
        for (int k = 1; k <= int'(NUM_MASTERS); k++) begin
            idx = {1'b0, last_q} + ExtW'(k);
            if (idx >= ExtW'(NUM_MASTERS)) begin
                idx = idx - ExtW'(NUM_MASTERS);
            end
            if (!found && m_cyc_i[idx[IdxW-1:0]]) begin
                found                  = 1'b1;
                pick_idx               = idx[IdxW-1:0];
                pick_oh[idx[IdxW-1:0]] = 1'b1;
            end
        end
    end

    // AND-OR mux of the owner's signals; everything reads zero while nobody is granted.
    always_comb begin
        owner_cyc = 1'b0;
        owner_stb = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = '0;
        s_sel_o   = '0;
        s_dat_o   = '0;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            if (grant_q[i]) begin
                owner_cyc = m_cyc_i[i];
                owner_stb = m_stb_i[i];
                s_we_o    = m_we_i[i];
                s_adr_o   = m_adr_i[32*i +: 32];
                s_sel_o   = m_sel_i[4*i +: 4];
                s_dat_o   = m_dat_i[32*i +: 32];
            end
        end
    end

    assign s_cyc_o = owner_cyc & (state_q != StIdle);
    // Strobe is masked outside BUSY so the slave never sees a duplicate request in GAP.
    assign s_stb_o = owner_cyc & owner_stb & (state_q == StBusy);
    // Acks outside an active strobe (e.g. late acks after a timeout) are dropped.
    assign ack_ok  = s_stb_o & s_ack_i;
    assign timeout = s_stb_o & ~s_ack_i & (wdog_q == TimeoutCnt);
    assign m_ack_o = ack_ok  ? grant_q : '0;
    assign m_err_o = timeout ? grant_q : '0;
    assign m_dat_o = s_dat_i;
    assign grant_o = grant_q;

    // Arbitration FSM with grant, pointer and watchdog state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= LastIdx;
            wdog_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    wdog_q <= '0;
                    if (|m_cyc_i) begin
                        grant_q <= pick_oh;
                        owner_q <= pick_idx;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (!owner_cyc) begin
                        state_q <= StIdle;
                        grant_q <= '0;
                        last_q  <= owner_q;
                        wdog_q  <= '0;
                    end else if (ack_ok || timeout) begin
                        state_q <= StGap;
                        wdog_q  <= '0;
                    end else if (s_stb_o) begin
                        wdog_q <= wdog_q + 8'd1;
                    end
                end
                StGap: begin
                    wdog_q <= '0;
                    if (owner_cyc) begin
                        state_q <= StBusy;
                    end else begin
                        state_q <= StIdle;
                        grant_q <= '0;
                        last_q  <= owner_q;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_sram_arb.sv
// Bench for wb_sram_arb: randomized Wishbone traffic checked against a transaction-level
// round-robin / watchdog model.
module tb_wb_sram_arb;

    localparam int N  = 3;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    m_cyc, m_stb, m_we;
    logic [32*N-1:0] m_adr, m_dat;
    logic [4*N-1:0]  m_sel;
    logic [31:0]     m_dat_o;
    logic [N-1:0]    m_ack_o, m_err_o, grant_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [31:0]     s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]      s_sel_o;
    logic            s_ack_i;

    int vectors    = 0;
    int errors     = 0;
    int model_last = N - 1;

    wb_sram_arb #(.NUM_MASTERS(N), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset   (reset),
        .m_cyc_i (m_cyc),
        .m_stb_i (m_stb),
        .m_we_i  (m_we),
        .m_adr_i (m_adr),
        .m_sel_i (m_sel),
        .m_dat_i (m_dat),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_adr_o (s_adr_o),
        .s_sel_o (s_sel_o),
        .s_dat_o (s_dat_o),
        .s_dat_i (s_dat_i),
        .s_ack_i (s_ack_i),
        .grant_o (grant_o)
    );

    always #5 clk = ~clk;

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Round robin as plain modular arithmetic on the last-served index.
    function automatic int model_pick(input logic [N-1:0] req);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (model_last + k) % N;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic req(input int m, input bit we);
        m_cyc[m]          = 1'b1;
        m_stb[m]          = 1'b1;
        m_we[m]           = we;
        m_adr[32*m +: 32] = $urandom;
        m_sel[4*m +: 4]   = 4'($urandom_range(1, 15));
        m_dat[32*m +: 32] = $urandom;
    endtask

    task automatic drop_m(input int m);
        m_cyc[m] = 1'b0;
        m_stb[m] = 1'b0;
    endtask

    // One transfer by master m: wait for grant, stall lat cycles, ack, then GAP.
    task automatic serve(input int m, input int lat, input bit drop);
        int          guard;
        logic [31:0] rd;
        guard = 0;
        while (grant_o === '0 && guard < 8) begin
            next();
            guard++;
        end
        #1;
        vectors++;
        if (grant_o !== oh(m)) begin
            errors++;
            $display("FAIL grant: got %b want %b", grant_o, oh(m));
        end
        vectors++;
        if ({s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o} !==
            {2'b11, m_we[m], m_adr[32*m +: 32], m_sel[4*m +: 4], m_dat[32*m +: 32]}) begin
            errors++;
            $display("FAIL slave_mux m%0d: got cyc%b stb%b we%b adr%h sel%h dat%h", m, s_cyc_o,
                     s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o);
        end
        for (int k = 0; k < lat; k++) begin
            vectors++;
            if ({m_ack_o, m_err_o, s_stb_o} !== {{(2*N){1'b0}}, 1'b1}) begin
                errors++;
                $display("FAIL stall: got ack %b err %b stb %b want 0 0 1", m_ack_o, m_err_o,
                         s_stb_o);
            end
            next();
            #1;
        end
        rd      = $urandom;
        s_ack_i = 1'b1;
        s_dat_i = rd;
        #1;
        vectors++;
        if ({m_ack_o, m_err_o, m_dat_o} !== {oh(m), {N{1'b0}}, rd}) begin
            errors++;
            $display("FAIL ack_route: got ack %b err %b dat %h want %b 0 %h", m_ack_o, m_err_o,
                     m_dat_o, oh(m), rd);
        end
        next();
        s_ack_i = 1'b0;
        if (drop) begin
            drop_m(m);
            model_last = m;
        end else begin
            m_adr[32*m +: 32] = $urandom;
            m_dat[32*m +: 32] = $urandom;
        end
        #1;
        vectors++;
        if ({s_stb_o, s_cyc_o, grant_o, m_ack_o} !== {1'b0, ~drop, oh(m), {N{1'b0}}}) begin
            errors++;
            $display("FAIL gap: got stb %b cyc %b grant %b ack %b want 0 %b %b 0", s_stb_o,
                     s_cyc_o, grant_o, m_ack_o, ~drop, oh(m));
        end
        next();
        #1;
        if (drop) begin
            vectors++;
            if (grant_o !== '0) begin
                errors++;
                $display("FAIL idle_after_drop: got grant %b want 000", grant_o);
            end
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        m_cyc   = '0;
        m_stb   = '0;
        m_we    = '0;
        m_adr   = '0;
        m_sel   = '0;
        m_dat   = '0;
        s_dat_i = '0;
        s_ack_i = 1'b0;
        repeat (2) next();
        vectors++;
        if ({grant_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o}
            !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got grant %b cyc %b stb %b adr %h", grant_o, s_cyc_o,
                     s_stb_o, s_adr_o);
        end
        m_cyc = '1;
        next();
        vectors++;
        if (grant_o !== '0) begin
            errors++;
            $display("FAIL reset_hold: got grant %b want 000", grant_o);
        end
        m_cyc      = '0;
        reset      = 1'b0;
        model_last = N - 1;
        next();
    endtask

    task automatic test_single_read();
        int m;
        req(0, 1'b0);
        m_adr[31:0] = 32'h0000_0100;
        #1;
        vectors++;
        if ({grant_o, s_cyc_o, s_stb_o} !== '0) begin
            errors++;
            $display("FAIL arb_cycle: got grant %b cyc %b stb %b want 0", grant_o, s_cyc_o,
                     s_stb_o);
        end
        m = model_pick(m_cyc);
        serve(m, 4, 1'b1);
    endtask

    task automatic run_round(input logic [N-1:0] reqs, input bit random_we);
        logic [N-1:0] pending;
        int           m;
        pending = reqs;
        for (int i = 0; i < N; i++) begin
            if (reqs[i]) req(i, random_we ? 1'($urandom_range(0, 1)) : 1'b1);
        end
        while (pending != '0) begin
            m = model_pick(pending);
            serve(m, $urandom_range(0, 3), 1'b1);
            pending[m] = 1'b0;
        end
    endtask

    task automatic test_round_robin();
        run_round('1, 1'b0);
        run_round('1, 1'b0);
        for (int r = 0; r < 12; r++) begin
            run_round(N'($urandom_range(1, (1 << N) - 1)), 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        int m;
        req(1, 1'b0);
        next();
        req(0, 1'b0);
        m = model_pick(3'b010);
        for (int b = 0; b < 3; b++) serve(m, $urandom_range(0, 4), 1'b0);
        serve(m, $urandom_range(0, 4), 1'b1);
        serve(model_pick(m_cyc), $urandom_range(0, 4), 1'b1);
    endtask

    task automatic test_timeout();
        int m;
        m = $urandom_range(0, N - 1);
        req(m, 1'($urandom_range(0, 1)));
        next();
        #1;
        for (int k = 0; k <= TO; k++) begin
            vectors++;
            if ({m_err_o, m_ack_o} !== {((k == TO) ? oh(m) : {N{1'b0}}), {N{1'b0}}}) begin
                errors++;
                $display("FAIL watchdog k=%0d: got err %b ack %b", k, m_err_o, m_ack_o);
            end
            if (k < TO) begin
                next();
                #1;
            end
        end
        next();
        drop_m(m);
        model_last = m;
        #1;
        vectors++;
        if ({m_err_o, s_stb_o} !== '0) begin
            errors++;
            $display("FAIL err_single_cycle: got err %b stb %b want 0", m_err_o, s_stb_o);
        end
        next();
        next();
        s_ack_i = 1'b1;
        s_dat_i = $urandom;
        #1;
        vectors++;
        if ({m_ack_o, m_err_o} !== '0) begin
            errors++;
            $display("FAIL late_ack: got ack %b err %b want 0", m_ack_o, m_err_o);
        end
        next();
        s_ack_i = 1'b0;
    endtask

    task automatic test_ack_timeout_race();
        int m;
        m = $urandom_range(0, N - 1);
        req(m, 1'b0);
        next();
        for (int k = 0; k < TO; k++) begin
            #1;
            vectors++;
            if (m_err_o !== '0) begin
                errors++;
                $display("FAIL race_early_err k=%0d: got %b want 000", k, m_err_o);
            end
            next();
        end
        s_ack_i = 1'b1;
        s_dat_i = $urandom;
        #1;
        vectors++;
        if ({m_ack_o, m_err_o} !== {oh(m), {N{1'b0}}}) begin
            errors++;
            $display("FAIL race: got ack %b err %b want %b 000", m_ack_o, m_err_o, oh(m));
        end
        next();
        s_ack_i = 1'b0;
        drop_m(m);
        model_last = m;
        next();
        next();
    endtask

    task automatic test_reset_midflight();
        int m;
        m = $urandom_range(0, N - 1);
        req(m, 1'b1);
        next();
        #1;
        vectors++;
        if (s_stb_o !== 1'b1) begin
            errors++;
            $display("FAIL busy_before_reset: got stb %b want 1", s_stb_o);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({s_cyc_o, s_stb_o, grant_o, m_ack_o, m_err_o} !== '0) begin
            errors++;
            $display("FAIL async_reset: got cyc %b stb %b grant %b", s_cyc_o, s_stb_o, grant_o);
        end
        m_cyc = '0;
        m_stb = '0;
        next();
        reset      = 1'b0;
        model_last = N - 1;
        next();
        run_round('1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_reset();
        test_round_robin();
        test_back_to_back();
        test_timeout();
        test_ack_timeout_race();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
